vrf_wb_arbiter: RTL and testbench

- Arbitrates between the vector ALU and the load/store unit for the single write port of the vector register file.
- Both requesters use valid/ready handshakes; arbitration is round-robin.
- Emits one registered write per cycle on WE3/A3/WD3/SFlag/LDFlag.
- Sits between the execute/memory stages and the register file; also drops illegal targets and reports them.

---
 rtl/vrf_wb_arbiter.sv | 117 +++++++++++
 tb/tb_vrf_wb_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vrf_wb_arbiter.sv
// Round-robin write-back arbiter for the vector register file port.
// Grants ALU or LSU, registers one write per cycle, drops bad targets.
module vrf_wb_arbiter #(
  parameter int NREG  = 10,
  parameter int NSCAL = 6,
  parameter int LANES = 6,
  parameter int LW    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [3:0]          alu_addr,
  input  logic [LANES*LW-1:0] alu_data,
  input  logic                lsu_valid,
  output logic                lsu_ready,
  input  logic [3:0]          lsu_addr,
  input  logic [LANES*LW-1:0] lsu_data,
  input  logic                lsu_sflag,
  output logic                WE3,
  output logic [3:0]          A3,
  output logic [LANES*LW-1:0] WD3,
  output logic                SFlag,
  output logic                LDFlag,
  output logic                err,
  output logic                last_gnt
);

  localparam logic [4:0] NREG_L  = 5'(NREG);
  localparam logic [4:0] NSCAL_L = 5'(NSCAL);

  logic                we_q, we_d;
  logic [3:0]          a3_q, a3_d;
  logic [LANES*LW-1:0] wd_q, wd_d;
  logic                sf_q, sf_d;
  logic                ld_q, ld_d;
  logic                err_q, err_d;
  logic                gnt_q, gnt_d;

  logic alu_ill;
  logic lsu_ill;

  assign alu_ready = !stall & alu_valid & (!lsu_valid | gnt_q);
  assign lsu_ready = !stall & lsu_valid & (!alu_valid | !gnt_q);

  assign alu_ill = {1'b0, alu_addr} >= NREG_L;
  assign lsu_ill = lsu_sflag ? ({1'b0, lsu_addr} >= NSCAL_L)
                             : ({1'b0, lsu_addr} >= NREG_L);

  // Illegal grants still move the pointer but leave the data regs alone.
  always_comb begin
    we_d  = 1'b0;
    a3_d  = a3_q;
    wd_d  = wd_q;
    sf_d  = sf_q;
    ld_d  = ld_q;
    err_d = err_q;
    gnt_d = gnt_q;
    unique case (1'b1)
      alu_ready: begin
        gnt_d = 1'b0;
        if (alu_ill) begin
          err_d = 1'b1;
        end else begin
          we_d = 1'b1;
          a3_d = alu_addr;
          wd_d = alu_data;
          sf_d = 1'b0;
          ld_d = 1'b0;
        end
      end
      lsu_ready: begin
        gnt_d = 1'b1;
        if (lsu_ill) begin
          err_d = 1'b1;
        end else begin
          we_d = 1'b1;
          a3_d = lsu_addr;
          wd_d = lsu_data;
          sf_d = lsu_sflag;
          ld_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q  <= 1'b0;
      a3_q  <= '0;
      wd_q  <= '0;
      sf_q  <= 1'b0;
      ld_q  <= 1'b0;
      err_q <= 1'b0;
      gnt_q <= 1'b0;
    end else begin
      we_q  <= we_d;
      a3_q  <= a3_d;
      wd_q  <= wd_d;
      sf_q  <= sf_d;
      ld_q  <= ld_d;
      err_q <= err_d;
      gnt_q <= gnt_d;
    end
  end

  assign WE3      = we_q;
  assign A3       = a3_q;
  assign WD3      = wd_q;
  assign SFlag    = sf_q;
  assign LDFlag   = ld_q;
  assign err      = err_q;
  assign last_gnt = gnt_q;

endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// Directed bench for vrf_wb_arbiter.
// Linear stimulus with immediate assertions and hand-computed values.
module tb_vrf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  alu_addr;
  logic [47:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [3:0]  lsu_addr;
  logic [47:0] lsu_data;
  logic        lsu_sflag;
  logic        WE3;
  logic [3:0]  A3;
  logic [47:0] WD3;
  logic        SFlag;
  logic        LDFlag;
  logic        err;
  logic        last_gnt;

  int n_cmp = 0;
  int n_err = 0;

  vrf_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_addr(alu_addr), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .lsu_addr(lsu_addr), .lsu_data(lsu_data),
    .lsu_sflag(lsu_sflag),
    .WE3(WE3), .A3(A3), .WD3(WD3),
    .SFlag(SFlag), .LDFlag(LDFlag),
    .err(err), .last_gnt(last_gnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_addr = '0; lsu_data = '0; lsu_sflag = 1'b0;
    #2;
    chk("rst_we",   WE3, 0);
    chk("rst_a3",   A3, 0);
    chk("rst_wd",   WD3, 0);
    chk("rst_sf",   SFlag, 0);
    chk("rst_ld",   LDFlag, 0);
    chk("rst_err",  err, 0);
    chk("rst_gnt",  last_gnt, 0);
    do_reset();

    // single ALU write
    alu_valid = 1'b1; alu_addr = 4'd4; alu_data = 48'h050403020100;
    #1;
    chk("alu1_rdy", alu_ready, 1);
    chk("alu1_lrdy", lsu_ready, 0);
    tick();
    alu_valid = 1'b0;
    chk("alu1_we", WE3, 1);
    chk("alu1_a3", A3, 4);
    chk("alu1_wd", WD3, 64'h050403020100);
    chk("alu1_sf", SFlag, 0);
    chk("alu1_ld", LDFlag, 0);
    tick();
    chk("alu1_we0", WE3, 0);
    chk("alu1_hold", A3, 4);

    // contention from reset: L A L A
    do_reset();
    alu_valid = 1'b1; alu_addr = 4'd6; alu_data = 48'h111111111111;
    lsu_valid = 1'b1; lsu_addr = 4'd7; lsu_data = 48'h222222222222;
    #1;
    chk("rr0_lrdy", lsu_ready, 1);
    chk("rr0_ardy", alu_ready, 0);
    tick();
    chk("rr1_we", WE3, 1);
    chk("rr1_a3", A3, 7);
    chk("rr1_ld", LDFlag, 1);
    chk("rr1_gnt", last_gnt, 1);
    chk("rr1_ardy", alu_ready, 1);
    tick();
    chk("rr2_we", WE3, 1);
    chk("rr2_a3", A3, 6);
    chk("rr2_wd", WD3, 64'h111111111111);
    chk("rr2_gnt", last_gnt, 0);
    tick();
    chk("rr3_we", WE3, 1);
    chk("rr3_a3", A3, 7);
    chk("rr3_gnt", last_gnt, 1);
    tick();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    chk("rr4_we", WE3, 1);
    chk("rr4_a3", A3, 6);
    chk("rr4_gnt", last_gnt, 0);
    tick();
    chk("rr5_we", WE3, 0);

    // scalar load, lane 0
    lsu_valid = 1'b1; lsu_sflag = 1'b1; lsu_addr = 4'd3;
    lsu_data = 48'h0000000000AA;
    tick();
    lsu_valid = 1'b0; lsu_sflag = 1'b0;
    chk("sld_we", WE3, 1);
    chk("sld_a3", A3, 3);
    chk("sld_sf", SFlag, 1);
    chk("sld_ld", LDFlag, 1);
    chk("sld_lane0", WD3[7:0], 8'hAA);
    chk("sld_gnt", last_gnt, 1);
    tick();
    chk("sld_we0", WE3, 0);

    // illegal ALU target
    alu_valid = 1'b1; alu_addr = 4'd12;
    #1;
    chk("ill_ardy", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    chk("ill_we", WE3, 0);
    chk("ill_err", err, 1);
    chk("ill_gnt", last_gnt, 0);
    chk("ill_a3", A3, 3);
    tick();
    chk("ill_sticky", err, 1);

    // illegal scalar load at the boundary
    do_reset();
    lsu_valid = 1'b1; lsu_sflag = 1'b1; lsu_addr = 4'd6;
    #1;
    chk("sill_rdy", lsu_ready, 1);
    tick();
    chk("sill_we", WE3, 0);
    chk("sill_err", err, 1);
    chk("sill_gnt", last_gnt, 1);
    // vector load to 6 is legal
    lsu_sflag = 1'b0; lsu_data = 48'hABCDEF012345;
    tick();
    lsu_valid = 1'b0;
    chk("vld6_we", WE3, 1);
    chk("vld6_a3", A3, 6);
    chk("vld6_sf", SFlag, 0);
    // ALU 9 legal, then stall with both valid
    alu_valid = 1'b1; alu_addr = 4'd9; alu_data = 48'h999999999999;
    tick();
    chk("a9_we", WE3, 1);
    chk("a9_a3", A3, 9);
    chk("a9_gnt", last_gnt, 0);
    stall = 1'b1;
    alu_addr = 4'd2; alu_data = 48'h020202020202;
    lsu_valid = 1'b1; lsu_addr = 4'd5; lsu_data = 48'h050505050505;
    #1;
    chk("st_ardy", alu_ready, 0);
    chk("st_lrdy", lsu_ready, 0);
    tick();
    chk("st1_we", WE3, 0);
    chk("st1_a3", A3, 9);
    tick();
    chk("st2_we", WE3, 0);
    tick();
    chk("st3_we", WE3, 0);
    chk("st3_gnt", last_gnt, 0);
    chk("st3_err", err, 1);
    stall = 1'b0;
    #1;
    chk("rel_lrdy", lsu_ready, 1);
    chk("rel_ardy", alu_ready, 0);
    tick();
    lsu_valid = 1'b0;
    chk("rel_a3", A3, 5);
    chk("rel_ld", LDFlag, 1);
    chk("rel_gnt", last_gnt, 1);
    tick();
    alu_valid = 1'b0;
    chk("rel2_we", WE3, 1);
    chk("rel2_a3", A3, 2);
    chk("rel2_wd", WD3, 64'h020202020202);

    // async reset while WE3 is high
    lsu_valid = 1'b1; lsu_addr = 4'd1;
    tick();
    lsu_valid = 1'b0;
    chk("pre_we", WE3, 1);
    chk("pre_gnt", last_gnt, 1);
    chk("pre_err", err, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_we", WE3, 0);
    chk("ar_err", err, 0);
    chk("ar_gnt", last_gnt, 0);
    chk("ar_a3", A3, 0);
    tick();
    chk("ar_next_we", WE3, 0);
    rst_n = 1'b1;
    tick();
    chk("post_we", WE3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
